// File: rtl/lstm_pkg.sv
// Shared types and width helpers for the LSTM sequencer.
package lstm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StAct,
    StCell,
    StNext,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    GATE_I,
    GATE_F,
    GATE_G,
    GATE_O
  } gate_e;

  // Index width for a range of n values, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned len_w(input int unsigned tmax);
    return idx_w(tmax + 1);
  endfunction

  function automatic int unsigned x_addr_w(input int unsigned tmax, input int unsigned nin);
    return idx_w(tmax * nin);
  endfunction

  function automatic int unsigned w_addr_w(input int unsigned nin, input int unsigned nhid);
    return idx_w(4 * nhid * (nin + nhid));
  endfunction

endpackage

// File: rtl/loop_cnt.sv
// Loadable up/down loop counter; exposes next value so callers can register derived outputs.
module loop_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  input  logic             down,
  input  logic [Width-1:0] last,
  output logic [Width-1:0] cnt,
  output logic [Width-1:0] nxt,
  output logic             tc
);

  logic [Width-1:0] cnt_q;

  always_comb begin
    nxt = cnt_q;
    if (load) begin
      nxt = load_val;
    end else if (en) begin
      nxt = down ? cnt_q - Width'(1) : cnt_q + Width'(1);
    end
  end

  // Terminal count: zero when counting down, 'last' when counting up.
  assign tc  = down ? (cnt_q == '0) : (cnt_q == last);
  assign cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (!xrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= nxt;
    end
  end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// LSTM sequencer: walks timestep / unit / gate / dot-product index and drives datapath strobes.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int unsigned NIN  = 16,
  parameter int unsigned NHID = 16,
  parameter int unsigned TMAX = 64,
  localparam int unsigned K   = NIN + NHID,
  localparam int unsigned LW  = len_w(TMAX),
  localparam int unsigned TW  = idx_w(TMAX),
  localparam int unsigned HW  = idx_w(NHID),
  localparam int unsigned KW  = idx_w(K),
  localparam int unsigned XW  = x_addr_w(TMAX, NIN),
  localparam int unsigned WW  = w_addr_w(NIN, NHID)
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          req,
  input  logic [LW-1:0] seq_len,
  input  logic          rev,
  output logic          busy,
  output logic          ack,
  output logic          mac_clear,
  output logic          mac_en,
  output logic          act_en,
  output logic          cell_wr,
  output logic          h_swap,
  output logic [1:0]    gate,
  output logic          src_sel,
  output logic          h_zero,
  output logic [XW-1:0] x_addr,
  output logic [HW-1:0] h_addr,
  output logic [WW-1:0] w_addr,
  output logic [HW-1:0] unit,
  output logic [TW-1:0] step
);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d, len_eff;
  logic          rev_q, rev_d;
  logic          first_q, first_d;

  logic          k_load, k_en, k_tc;
  logic          g_load, g_en, g_tc;
  logic          u_load, u_en, u_tc;
  logic          t_load, t_en, t_tc;
  logic [KW-1:0] k_q, k_nxt;
  logic [1:0]    g_q, g_nxt;
  logic [HW-1:0] u_q, u_nxt;
  logic [TW-1:0] t_q, t_nxt, t_load_val;

  assign len_eff = (32'(seq_len) > TMAX) ? LW'(TMAX) : seq_len;

  loop_cnt #(.Width(KW)) u_k_cnt (
    .clk(clk), .xrst(xrst), .load(k_load), .load_val('0), .en(k_en), .down(1'b0),
    .last(KW'(K - 1)), .cnt(k_q), .nxt(k_nxt), .tc(k_tc)
  );

  loop_cnt #(.Width(2)) u_g_cnt (
    .clk(clk), .xrst(xrst), .load(g_load), .load_val('0), .en(g_en), .down(1'b0),
    .last(2'(GATE_O)), .cnt(g_q), .nxt(g_nxt), .tc(g_tc)
  );

  loop_cnt #(.Width(HW)) u_u_cnt (
    .clk(clk), .xrst(xrst), .load(u_load), .load_val('0), .en(u_en), .down(1'b0),
    .last(HW'(NHID - 1)), .cnt(u_q), .nxt(u_nxt), .tc(u_tc)
  );

  loop_cnt #(.Width(TW)) u_t_cnt (
    .clk(clk), .xrst(xrst), .load(t_load), .load_val(t_load_val), .en(t_en), .down(rev_q),
    .last(TW'(len_q - LW'(1))), .cnt(t_q), .nxt(t_nxt), .tc(t_tc)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rev_d      = rev_q;
    first_d    = first_q;
    k_load     = 1'b0;
    k_en       = 1'b0;
    g_load     = 1'b0;
    g_en       = 1'b0;
    u_load     = 1'b0;
    u_en       = 1'b0;
    t_load     = 1'b0;
    t_en       = 1'b0;
    t_load_val = rev ? TW'(len_eff - LW'(1)) : '0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          len_d  = len_eff;
          rev_d  = rev;
          k_load = 1'b1;
          g_load = 1'b1;
          u_load = 1'b1;
          t_load = 1'b1;
          if (len_eff != '0) begin
            state_d = StClear;
            first_d = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StClear: state_d = StAccum;
      StAccum: begin
        if (k_tc) begin
          k_load  = 1'b1;
          state_d = StAct;
        end else begin
          k_en = 1'b1;
        end
      end
      StAct: begin
        if (g_tc) begin
          state_d = StCell;
        end else begin
          g_en    = 1'b1;
          state_d = StClear;
        end
      end
      StCell: begin
        g_load = 1'b1;
        if (u_tc) begin
          state_d = StNext;
        end else begin
          u_en    = 1'b1;
          state_d = StClear;
        end
      end
      StNext: begin
        u_load  = 1'b1;
        first_d = 1'b0;
        if (t_tc) begin
          state_d = StDone;
        end else begin
          t_en    = 1'b1;
          state_d = StClear;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  logic run_d, gate_vis_d, unit_vis_d, acc_d, x_sel_d;

  always_comb begin
    run_d      = (state_d == StClear) || (state_d == StAccum) || (state_d == StAct) ||
                 (state_d == StCell) || (state_d == StNext);
    gate_vis_d = (state_d == StClear) || (state_d == StAccum) || (state_d == StAct);
    unit_vis_d = gate_vis_d || (state_d == StCell);
    acc_d      = (state_d == StAccum);
    x_sel_d    = 32'(k_nxt) < NIN;
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      rev_q     <= 1'b0;
      first_q   <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      mac_clear <= 1'b0;
      mac_en    <= 1'b0;
      act_en    <= 1'b0;
      cell_wr   <= 1'b0;
      h_swap    <= 1'b0;
      gate      <= '0;
      src_sel   <= 1'b0;
      h_zero    <= 1'b0;
      x_addr    <= '0;
      h_addr    <= '0;
      w_addr    <= '0;
      unit      <= '0;
      step      <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rev_q     <= rev_d;
      first_q   <= first_d;
      busy      <= (state_d != StIdle);
      ack       <= (state_d == StDone);
      mac_clear <= (state_d == StClear);
      mac_en    <= acc_d;
      act_en    <= (state_d == StAct);
      cell_wr   <= (state_d == StCell);
      h_swap    <= (state_d == StNext);
      gate      <= gate_vis_d ? g_nxt : '0;
      src_sel   <= acc_d && !x_sel_d;
      h_zero    <= first_d && run_d;
      x_addr    <= (acc_d && x_sel_d) ? XW'(32'(t_nxt) * NIN + 32'(k_nxt)) : '0;
      h_addr    <= (acc_d && !x_sel_d) ? HW'(32'(k_nxt) - NIN) : '0;
      w_addr    <= acc_d ? WW'((32'(g_nxt) * NHID + 32'(u_nxt)) * K + 32'(k_nxt)) : '0;
      unit      <= unit_vis_d ? u_nxt : '0;
      step      <= run_d ? t_nxt : '0;
    end
  end

endmodule
